// File: rtl/tfb_pkg.sv
// Shared definitions for the text frame buffer: fill-engine states and the
// control codes recognised on the cursor write path.
package tfb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ALL = 2'd1,
        CLEAR_ROW = 2'd2
    } tfb_state_e;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

endpackage

// File: rtl/text_frame_buffer_char_ram.sv
// Simple dual-port character store: one write port, one registered read-first
// read port. Structured so synthesis maps it onto block RAM.
module char_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    // Read register samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_frame_buffer.sv
// Character frame buffer: CPU direct/cursor writes, hardware scroll via row
// rotation, fill engine for clears, registered rotated read path.
module text_frame_buffer
    import tfb_pkg::*;
#(
    parameter int                COLS      = 16,
    parameter int                ROWS      = 4,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(8'h20),
    parameter int                ADDR_W    = $clog2(ROWS * COLS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [CHAR_W-1:0]        wr_char,
    input  logic                     put_en,
    input  logic [CHAR_W-1:0]        put_char,
    input  logic                     scroll_req,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [CHAR_W-1:0]        rd_char,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic [$clog2(COLS)-1:0]  cur_col
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int AW1   = ADDR_W + 1;

    localparam logic [ADDR_W:0]   CELLS_L      = AW1'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_LA  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] LAST_COL_CNT = ADDR_W'(COLS - 1);
    localparam logic [RW-1:0]     LAST_ROW     = RW'(ROWS - 1);
    localparam logic [CW-1:0]     LAST_COL     = CW'(COLS - 1);

    tfb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [RW-1:0]     top_row_q, top_row_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              busy_q, busy_d;
    logic              rd_oob_q, rd_oob_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CHAR_W-1:0] wdata;
    logic [ADDR_W-1:0] rd_phys;
    logic [ADDR_W-1:0] top_base;
    logic [ADDR_W-1:0] cur_lin;
    logic [CHAR_W-1:0] ram_rdata;
    logic              adv;
    logic              do_scroll;

    // Rotation as (logical + top_row*COLS) mod CELLS; both operands are below
    // CELLS, so one conditional subtract is enough and no divider is needed.
    function automatic logic [ADDR_W-1:0] to_phys(input logic [ADDR_W-1:0] la,
                                                   input logic [ADDR_W-1:0] base);
        logic [ADDR_W:0] s;
        s = {1'b0, la} + {1'b0, base};
        if (s >= CELLS_L) begin
            s = s - CELLS_L;
        end
        return s[ADDR_W-1:0];
    endfunction

    always_comb begin
        top_base = ADDR_W'(top_row_q) * ADDR_W'(COLS);
        cur_lin  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    end

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        top_row_d = top_row_q;
        row_d     = row_q;
        col_d     = col_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = FILL_CHAR;
        adv       = 1'b0;
        do_scroll = 1'b0;

        case (state_q)
            CLEAR_ALL: begin
                we    = 1'b1;
                waddr = fill_q;
                if (fill_q == LAST_CELL) begin
                    state_d = IDLE;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            CLEAR_ROW: begin
                we    = 1'b1;
                waddr = to_phys(LAST_ROW_LA + fill_q, top_base);
                if (fill_q == LAST_COL_CNT) begin
                    state_d = IDLE;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            default: begin
                if (clear_req) begin
                    top_row_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                    fill_d    = '0;
                    state_d   = CLEAR_ALL;
                end else if (scroll_req) begin
                    do_scroll = 1'b1;
                end else if (put_en) begin
                    if (put_char == CHAR_W'(CH_LF)) begin
                        col_d = '0;
                        adv   = 1'b1;
                    end else if (put_char == CHAR_W'(CH_CR)) begin
                        col_d = '0;
                    end else begin
                        we    = 1'b1;
                        waddr = to_phys(cur_lin, top_base);
                        wdata = put_char;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            adv   = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else if (wr_en && ({1'b0, wr_addr} < CELLS_L)) begin
                    we    = 1'b1;
                    waddr = to_phys(wr_addr, top_base);
                    wdata = wr_char;
                end

                if (adv) begin
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        do_scroll = 1'b1;
                    end
                end

                // The cursor write above still uses the pre-scroll rotation.
                if (do_scroll) begin
                    top_row_d = (top_row_q == LAST_ROW) ? '0 : top_row_q + 1'b1;
                    fill_d    = '0;
                    state_d   = CLEAR_ROW;
                end
            end
        endcase

        busy_d   = (state_d != IDLE);
        rd_oob_d = ({1'b0, rd_addr} >= CELLS_L);
        rd_phys  = rd_oob_d ? '0 : to_phys(rd_addr, top_base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ALL;
            fill_q    <= '0;
            top_row_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b1;
            rd_oob_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            top_row_q <= top_row_d;
            row_q     <= row_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            rd_oob_q  <= rd_oob_d;
        end
    end

    char_ram #(
        .DEPTH (CELLS),
        .WIDTH (CHAR_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we && !rst),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    assign rd_char = rd_oob_q ? FILL_CHAR : ram_rdata;
    assign busy    = busy_q;
    assign cur_row = row_q;
    assign cur_col = col_q;

endmodule
